mul_div_seq: RTL and testbench
==============================

Name: mul_div_seq

Overview:
- Iterative multicycle multiply/divide responder that the execute stage drives through a level-based start/done handshake.
- Operand and opcode inputs come from the execute-stage forwarded operands. Hi/lo results feed the execute-stage algebra result registers and the ALU result mux.
- The block owns the whole multicycle sequence. The execute stage only holds its request and stalls until done.

Parameters:
- WIDTH, 16, operand width; results are 2*WIDTH split into hi/lo halves.
- ITER, 16, number of iteration cycles; must equal WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  request level; held high by the requester until done is seen.
- op  input  2  operation select: 00 none, 01 unsigned MUL, 10 signed MUL, 11 unsigned DIV.
- opA  input  WIDTH  multiplicand or dividend.
- opB  input  WIDTH  multiplier or divisor.
- abort  input  1  pipeline flush; kills an in-flight operation.
- busy  output  1  high while iterating (RUN state).
- done  output  1  result valid; high in DONE state.
- div_by_zero  output  1  sticky for the result of the last DIV with opB==0.
- hi_bits  output  WIDTH  MUL: product[31:16]; DIV: remainder.
- lo_bits  output  WIDTH  MUL: product[15:0]; DIV: quotient.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - State goes to IDLE.
  - busy=0, done=0, div_by_zero=0, hi_bits=0, lo_bits=0; iteration counter = 0.
  - Reset overrides abort and start, including in mid-operation.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 with op in {01,10,11} and opB!=0 (or op != 11): latch operands, clear accumulator, counter=0, go to RUN.
  - Signed MUL: latch |opA| and |opB|; remember sign = opA[15]^opB[15].
  - start=1 with op=00: hi/lo = 0, go straight to DONE.
  - start=1 with op=11 and opB=0: lo=16'hFFFF, hi=opA, div_by_zero=1, go straight to DONE (done in the cycle after start).
  - Every new start clears div_by_zero unless the new op is itself a divide by zero.
- RUN:
  - One iteration per cycle, with busy=1.
  - MUL: shift-add, 32-bit accumulator.
  - DIV: restoring division, one quotient bit per cycle, MSB first, 17-bit partial remainder.
  - Counter increments each cycle. After iteration ITER-1, go to DONE.
  - On entering DONE, hi/lo are loaded. Signed MUL negates the 32-bit result (two's complement) if sign=1; note -32768*-32768 = 0x40000000.
  - start, op and operands are ignored in RUN: they are latched at the start cycle only.
- Latency: start seen in cycle 0 for MUL/DIV gives done=1 in cycle ITER+1 (17).
- DONE:
  - done=1; hi_bits/lo_bits valid.
  - Stays in DONE while start=1 (4-phase handshake).
  - Goes to IDLE on the edge where start=0, so done drops the cycle after start drops.
  - A held start never causes a restart.
- Between operations: hi_bits, lo_bits and div_by_zero hold their values through IDLE until the next operation completes.
- abort=1 at an edge in RUN or DONE: state goes to IDLE, busy=0, done=0, and hi/lo keep their previous completed values.
  - abort has priority over start in the same cycle.
  - abort in IDLE has no effect and blocks a start in that same cycle.
- Arithmetic and counter width:
  - All arithmetic is unsigned modulo 2^32, except for the signed-MUL sign fix-up.
  - The counter is $clog2(ITER)+1 bits wide and never wraps while in RUN.

Test Plan:
- Reset with reset_n=0 while in RUN at counter 8 -> next cycle busy=0, done=0, hi=lo=0, and the block accepts a new start.
- Unsigned MUL: op=01, opA=16'h1234, opB=16'h0010, start held -> done first high in cycle 17 with hi=16'h0001, lo=16'h2340; done stays high while start=1 and drops one cycle after start=0.
- Signed MUL: op=10, opA=16'hFFFD (-3), opB=16'h0005 -> hi=16'hFFFF, lo=16'hFFF1. Then opA=opB=16'h8000 -> hi=16'h4000, lo=16'h0000.
- DIV: op=11, opA=100, opB=7 -> done in cycle 17 with lo=16'h000E, hi=16'h0002, div_by_zero=0. Then opA=16'h1234, opB=0 -> done in cycle 1 with lo=16'hFFFF, hi=16'h1234, div_by_zero=1.
- Abort: start MUL 16'h00FF*16'h00FF, assert abort in cycle 8 -> idle next cycle, no done pulse, hi/lo unchanged. Then start DIV 9/2 -> lo=4, hi=1 after 17 cycles.
- Back-to-back: keep start high across done for 5 cycles -> no second busy. Drop start for 1 cycle and raise it with new operands -> new operation completes with the correct result.

Source files
------------

// File: rtl/mul_div_seq_if.sv
// Request/result bundle between the execute stage and the multicycle mul/div unit.
interface mul_div_seq_if #(parameter int WIDTH = 16);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             abort;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi_bits;
  logic [WIDTH-1:0] lo_bits;

  modport master (output start, op, opA, opB, abort,
                  input  busy, done, div_by_zero, hi_bits, lo_bits);
  modport slave  (input  start, op, opA, opB, abort,
                  output busy, done, div_by_zero, hi_bits, lo_bits);
endinterface

// File: rtl/mul_div_seq.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle,
// with a level start/done handshake towards the execute stage.
//
// state | meaning
// IDLE  | waiting for start; results from the last operation held
// RUN   | iterating, one multiply/divide step per cycle (busy=1)
// DONE  | result valid (done=1) until start drops
module mul_div_seq #(
  parameter int WIDTH = 16,
  parameter int ITER  = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  mul_div_seq_if.slave  bus
);
  localparam int CW = $clog2(ITER) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_nx;
  logic [CW-1:0]      cnt_q;
  logic [1:0]         op_q;
  logic               sign_q;
  logic [2*WIDTH-1:0] acc_q, a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               dz_q;

  logic [2*WIDTH-1:0] acc_nx, a_nx, prod_fix;
  logic [WIDTH-1:0]   b_nx, rem_sub, abs_a, abs_b;
  logic [WIDTH:0]     rem_sh;
  logic               rem_ge, last, is_dz, accept;

  assign last   = (cnt_q == CW'(ITER - 1));
  assign is_dz  = (bus.op == 2'b11) && (bus.opB == '0);
  assign accept = bus.start && !bus.abort;
  assign abs_a  = bus.opA[WIDTH-1] ? (~bus.opA + 1'b1) : bus.opA;
  assign abs_b  = bus.opB[WIDTH-1] ? (~bus.opB + 1'b1) : bus.opB;

  // a_q holds the (shifting) multiplicand or the divisor; b_q the multiplier
  // or the dividend that turns into the quotient; acc_q the product or remainder.
  always_comb begin
    acc_nx  = acc_q;
    a_nx    = a_q;
    b_nx    = b_q;
    rem_sh  = '0;
    rem_sub = '0;
    rem_ge  = 1'b0;
    if (op_q == 2'b11) begin
      rem_sh  = {acc_q[WIDTH-1:0], b_q[WIDTH-1]};
      rem_ge  = rem_sh >= {1'b0, a_q[WIDTH-1:0]};
      rem_sub = rem_sh[WIDTH-1:0] - a_q[WIDTH-1:0];
      acc_nx  = {{WIDTH{1'b0}}, (rem_ge ? rem_sub : rem_sh[WIDTH-1:0])};
      b_nx    = {b_q[WIDTH-2:0], rem_ge};
    end else begin
      acc_nx = acc_q + (b_q[0] ? a_q : '0);
      a_nx   = a_q << 1;
      b_nx   = b_q >> 1;
    end
  end

  assign prod_fix = sign_q ? (~acc_nx + (2*WIDTH)'(1)) : acc_nx;

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_nx = ((bus.op == 2'b00) || is_dz) ? S_DONE : S_RUN;
      S_RUN:   if (bus.abort) state_nx = S_IDLE;
               else if (last) state_nx = S_DONE;
      S_DONE:  if (bus.abort || !bus.start) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy        = (state_q == S_RUN);
    bus.done        = (state_q == S_DONE);
    bus.div_by_zero = dz_q;
    bus.hi_bits     = hi_q;
    bus.lo_bits     = lo_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      op_q   <= '0;
      sign_q <= 1'b0;
      acc_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      dz_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          dz_q   <= is_dz;
          cnt_q  <= '0;
          acc_q  <= '0;
          op_q   <= bus.op;
          sign_q <= 1'b0;
          if (bus.op == 2'b00) begin
            hi_q <= '0;
            lo_q <= '0;
          end else if (is_dz) begin
            hi_q <= bus.opA;
            lo_q <= '1;
          end else if (bus.op == 2'b10) begin
            a_q    <= {{WIDTH{1'b0}}, abs_a};
            b_q    <= abs_b;
            sign_q <= bus.opA[WIDTH-1] ^ bus.opB[WIDTH-1];
          end else if (bus.op == 2'b11) begin
            a_q <= {{WIDTH{1'b0}}, bus.opB};
            b_q <= bus.opA;
          end else begin
            a_q <= {{WIDTH{1'b0}}, bus.opA};
            b_q <= bus.opB;
          end
        end
        S_RUN: if (!bus.abort) begin
          cnt_q <= cnt_q + 1'b1;
          acc_q <= acc_nx;
          a_q   <= a_nx;
          b_q   <= b_nx;
          if (last) begin
            if (op_q == 2'b11) begin
              hi_q <= acc_nx[WIDTH-1:0];
              lo_q <= b_nx;
            end else begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_div_seq.sv
// Scoreboard bench for mul_div_seq: expected results are queued at request
// time and popped when done rises.
module tb_mul_div_seq;
  logic clk = 1'b0;
  logic reset_n = 1'b0;

  mul_div_seq_if #(.WIDTH(16)) bus();

  mul_div_seq #(.WIDTH(16), .ITER(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] hi;
    logic [15:0] lo;
    logic        dz;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] last_hi = '0;
  logic [15:0] last_lo = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    logic [31:0]        up;
    logic signed [31:0] sa, sbv, sp;
    e = '0;
    case (o)
      2'b01: begin up = {16'h0, a} * {16'h0, b}; e.hi = up[31:16]; e.lo = up[15:0]; end
      2'b10: begin
        sa = {{16{a[15]}}, a}; sbv = {{16{b[15]}}, b}; sp = sa * sbv;
        e.hi = sp[31:16]; e.lo = sp[15:0];
      end
      2'b11: begin
        if (b == 16'h0) begin e.hi = a; e.lo = 16'hFFFF; e.dz = 1'b1; end
        else begin e.hi = a % b; e.lo = a / b; end
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] a,
                        input logic [15:0] b, input int lat);
    exp_t e;
    int   n;
    sb.push_back(model(o, a, b));
    bus.op = o; bus.opA = a; bus.opB = b; bus.start = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.done && n < 40);
    check({tag, "_latency"}, n, lat);
    e = sb.pop_front();
    check({tag, "_hi"}, bus.hi_bits, e.hi);
    check({tag, "_lo"}, bus.lo_bits, e.lo);
    check({tag, "_dz"}, bus.div_by_zero, e.dz);
    last_hi = e.hi;
    last_lo = e.lo;
  endtask

  task automatic release_start(input string tag);
    bus.start = 1'b0;
    tick();
    check({tag, "_done_drop"}, bus.done, 1'b0);
  endtask

  initial begin
    int seen;
    bus.start = 1'b0; bus.op = 2'b00; bus.opA = '0; bus.opB = '0; bus.abort = 1'b0;
    tick(); tick();
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_hi",   bus.hi_bits, 16'h0);
    check("rst_lo",   bus.lo_bits, 16'h0);
    check("rst_dz",   bus.div_by_zero, 1'b0);
    reset_n = 1'b1;
    tick();

    run_op("umul", 2'b01, 16'h1234, 16'h0010, 17);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("umul_hold", bus.done, 1'b1);
    end
    release_start("umul");

    run_op("smul_neg", 2'b10, 16'hFFFD, 16'h0005, 17);
    release_start("smul_neg");
    run_op("smul_min", 2'b10, 16'h8000, 16'h8000, 17);
    release_start("smul_min");

    run_op("dzero", 2'b11, 16'h1234, 16'h0000, 1);
    release_start("dzero");
    check("dz_sticky_idle", bus.div_by_zero, 1'b1);
    run_op("nop", 2'b00, 16'hAAAA, 16'h5555, 1);
    release_start("nop");
    run_op("div", 2'b11, 16'd100, 16'd7, 17);
    release_start("div");

    // abort mid-run: no done, results of the previous op retained
    bus.op = 2'b01; bus.opA = 16'h00FF; bus.opB = 16'h00FF; bus.start = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("abort_busy_before", bus.busy, 1'b1);
    bus.abort = 1'b1; bus.start = 1'b0;
    tick();
    bus.abort = 1'b0;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.done, 1'b0);
    check("abort_hi", bus.hi_bits, last_hi);
    check("abort_lo", bus.lo_bits, last_lo);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.done || bus.busy) seen++;
    end
    check("abort_quiet", seen, 0);

    // abort in IDLE blocks a simultaneous start
    bus.abort = 1'b1; bus.start = 1'b1;
    tick();
    check("idle_abort_blocks", bus.busy, 1'b0);
    bus.abort = 1'b0; bus.start = 1'b0;
    tick();

    run_op("div9_2", 2'b11, 16'd9, 16'd2, 17);
    release_start("div9_2");

    run_op("b2b_first", 2'b01, 16'h0102, 16'h0304, 17);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("b2b_no_busy", bus.busy, 1'b0);
      check("b2b_done_held", bus.done, 1'b1);
    end
    release_start("b2b");
    run_op("b2b_second", 2'b10, 16'h7FFF, 16'hFFFF, 17);
    release_start("b2b_second");

    for (int k = 0; k < 6; k++) begin
      logic [1:0]  o;
      logic [15:0] a, b;
      o = 2'($urandom_range(1, 3));
      a = 16'($urandom);
      b = 16'($urandom);
      run_op("rand", o, a, b, (o == 2'b11 && b == 16'h0) ? 1 : 17);
      release_start("rand");
    end

    // reset in the middle of RUN at counter 8
    bus.op = 2'b01; bus.opA = 16'hFFFF; bus.opB = 16'hFFFF; bus.start = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    reset_n = 1'b0; bus.start = 1'b0;
    tick();
    check("mrst_busy", bus.busy, 1'b0);
    check("mrst_done", bus.done, 1'b0);
    check("mrst_hi", bus.hi_bits, 16'h0);
    check("mrst_lo", bus.lo_bits, 16'h0);
    reset_n = 1'b1;
    tick();
    run_op("post_rst", 2'b11, 16'hBEEF, 16'h0013, 17);
    release_start("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
